match_result_queue: RTL
=======================

MATCH_RESULT_QUEUE -- requirements
Module: match_result_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, the number of queue entries; it SHALL be a power of two, 2..64.
REQ-002 The block SHALL have port clk, input, 1, system clock; every register is clocked on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port proc_start, input, 1, one-cycle pulse at the start of a new search job.
REQ-005 The block SHALL have port proc_match, input, 1, one-cycle pulse qualifying proc_byte_pos and proc_match_char.
REQ-006 The block SHALL have port proc_byte_pos, input, 16, byte offset of the matching string.
REQ-007 The block SHALL have port proc_match_char, input, 8, the first character of the matching string.
REQ-008 The block SHALL have port rd_req, input, 1, one-cycle pulse from the command parser requesting one report.
REQ-009 The block SHALL have port txd_ready_next, input, 1, asserted when the transmitter accepts a byte on the next cycle.
REQ-010 The block SHALL have port txd_start, output, 1, one-cycle byte strobe to the transmitter.
REQ-011 The block SHALL have port txd_data, output, 8, report byte, valid while txd_start is high.
REQ-012 The block SHALL have port q_count, output, 7, number of queued entries.
REQ-013 The block SHALL have ports q_empty, output, 1, and q_full, output, 1, giving the queue status.
REQ-014 The block SHALL have port overflow, output, 1, a sticky flag meaning a match was dropped.
REQ-015 The block SHALL have port drop_count, output, 8, the dropped-match count (see Configuration).
REQ-016 The block SHALL have port busy, output, 1, high while any state other than IDLE is active.

Function
REQ-017 Each queue entry SHALL be 24 bits: {byte_pos[15:0], char[7:0]}; the queue order SHALL be FIFO.
REQ-018 When proc_match=1 and the queue is not full, the entry SHALL be written that cycle, and q_count SHALL update the next cycle.
REQ-019 When proc_match=1 and the queue is full with no pop in the same cycle, the entry SHALL be dropped and overflow SHALL be set.
REQ-020 When a push and a pop occur in the same cycle, both SHALL take effect, including when full, and q_count SHALL be unchanged.
REQ-021 The FSM SHALL have states IDLE, HDR, POS_HI, POS_LO, CHR.
REQ-022 In IDLE, rd_req SHALL move the FSM to HDR; if the queue is non-empty, the head entry SHALL be popped into a holding register in that same cycle; rd_req outside IDLE SHALL be ignored.
REQ-023 In HDR, txd_data SHALL be 0x01 if an entry was latched, else 0x00; the 0x00 case SHALL return to IDLE after the byte is sent.
REQ-024 POS_HI, POS_LO and CHR SHALL send byte_pos[15:8], byte_pos[7:0] and char respectively; CHR SHALL return to IDLE.
REQ-025 In each send state, txd_start SHALL pulse for exactly one cycle, in the first cycle with txd_ready_next=1, and the FSM SHALL advance on that cycle.
REQ-026 Minimum latency SHALL be 1 cycle from rd_req to the first txd_start.
REQ-027 proc_start SHALL clear the pointers, q_count and overflow, and SHALL clear drop_count when the counter is compiled in.
REQ-028 proc_start SHALL NOT abort an in-flight report; the report SHALL finish from the holding register.
REQ-029 proc_start coincident with proc_match SHALL leave the queue holding exactly that one new entry.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE, the pointers and q_count to 0, q_empty to 1, q_full to 0, overflow to 0, drop_count to 0, txd_start to 0, txd_data to 0x00 and busy to 0.
REQ-031 Reset during a report SHALL abandon the report immediately, with no further txd_start.

Configuration
REQ-032 With macro MATCH_QUEUE_DROP_COUNT_EN defined, drop_count SHALL increment by 1 for each dropped match and SHALL saturate at 0xFF.
REQ-033 Without MATCH_QUEUE_DROP_COUNT_EN, drop_count SHALL be tied to 0 and no counter register SHALL be synthesised; overflow behaviour SHALL be unchanged.

Structure
REQ-034 Report header codes (0x01 entry, 0x00 empty) and the entry width of 24 SHALL be constants in the shared md5_pkg package.
REQ-035 Storage SHALL be the sub-module match_sync_fifo (a synchronous FIFO with push, pop, count, full and empty), with the FSM in match_result_queue.

Verification
REQ-036 The bench SHALL cover: reset, then rd_req with txd_ready_next=1 -> single byte 0x00, busy low after.
REQ-037 The bench SHALL cover: a match at pos 0x1234, char 0x41, then rd_req -> bytes 01 12 34 41 on consecutive cycles, and q_count 1->0.
REQ-038 The bench SHALL cover: DEPTH+2 matches with no reads -> q_full=1, overflow=1, drop_count=2 (2 dropped; 0 without the macro), and subsequent reads return the first DEPTH entries in order.
REQ-039 The bench SHALL cover: full queue with proc_match in the cycle rd_req pops -> no drop, q_count stays DEPTH.
REQ-040 The bench SHALL cover: txd_ready_next held low 5 cycles in POS_LO -> no txd_start until release, then exactly one strobe.
REQ-041 The bench SHALL cover: proc_start mid-report -> the report completes correctly, then q_count=0 and overflow=0.

Source files
------------

// File: rtl/md5_pkg.sv
// ============================================================================
// md5_pkg : shared constants and types for the match result path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package md5_pkg;

  localparam int         ENTRY_W       = 24;
  localparam logic [7:0] RPT_HDR_ENTRY = 8'h01;
  localparam logic [7:0] RPT_HDR_EMPTY = 8'h00;

  typedef struct packed {
    logic [15:0] pos;
    logic [7:0]  chr;
  } match_entry_t;

  function automatic match_entry_t pack_entry(input logic [15:0] pos, input logic [7:0] chr);
    match_entry_t e;
    e.pos = pos;
    e.chr = chr;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/match_sync_fifo.sv
// ============================================================================
// match_sync_fifo : synchronous FIFO of match entries with count/full/empty
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module match_sync_fifo
  import md5_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [ENTRY_W-1:0] i_din,
  output logic [ENTRY_W-1:0] o_dout,
  output logic [6:0]         o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wptr;
  logic [AW-1:0]      r_rptr;
  logic [6:0]         r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_wr_en;
  logic [AW-1:0]      w_wr_addr;

  assign o_full  = (r_count == 7'(DEPTH));
  assign o_empty = (r_count == 7'd0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so a full queue still accepts a push.
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);
  assign w_wr_en   = !reset && (i_clr ? i_push : w_push);
  assign w_wr_addr = i_clr ? '0 : r_wptr;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 7'd0;
    end else if (i_clr) begin
      r_rptr  <= '0;
      r_wptr  <= i_push ? AW'(1) : '0;
      r_count <= i_push ? 7'd1 : 7'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + {6'd0, w_push} - {6'd0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/match_result_queue.sv
// ============================================================================
// match_result_queue : queues search matches and serialises reports on request
// Option  : MATCH_QUEUE_DROP_COUNT_EN enables the saturating dropped-match counter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module match_result_queue
  import md5_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        proc_start,
  input  logic        proc_match,
  input  logic [15:0] proc_byte_pos,
  input  logic [7:0]  proc_match_char,
  input  logic        rd_req,
  input  logic        txd_ready_next,
  output logic        txd_start,
  output logic [7:0]  txd_data,
  output logic [6:0]  q_count,
  output logic        q_empty,
  output logic        q_full,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_POS_HI = 3'd2;
  localparam logic [2:0] S_POS_LO = 3'd3;
  localparam logic [2:0] S_CHR    = 3'd4;

  logic [2:0]   r_state;
  match_entry_t r_hold;
  logic         r_has;
  logic         r_overflow;

  match_entry_t w_head;
  logic         w_pop;
  logic         w_drop;
  logic         w_send;
  logic [7:0]   w_byte;

  match_sync_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (proc_start),
    .i_push  (proc_match),
    .i_pop   (w_pop),
    .i_din   (pack_entry(proc_byte_pos, proc_match_char)),
    .o_dout  (w_head),
    .o_count (q_count),
    .o_full  (q_full),
    .o_empty (q_empty)
  );

  assign w_pop  = (r_state == S_IDLE) && rd_req && !q_empty;
  assign w_drop = proc_match && q_full && !w_pop && !proc_start;
  assign w_send = (r_state != S_IDLE);

  // Strobe is gated by reset so an abandoned report emits nothing more.
  assign txd_start = w_send && txd_ready_next && !reset;
  assign txd_data  = txd_start ? w_byte : 8'h00;
  assign busy      = w_send;
  assign overflow  = r_overflow;

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      S_HDR:    w_byte = r_has ? RPT_HDR_ENTRY : RPT_HDR_EMPTY;
      S_POS_HI: w_byte = r_hold.pos[15:8];
      S_POS_LO: w_byte = r_hold.pos[7:0];
      S_CHR:    w_byte = r_hold.chr;
      default:  w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_has   <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_state <= S_HDR;
            r_has   <= !q_empty;
            if (!q_empty) begin
              r_hold <= w_head;
            end
          end
        end
        S_HDR: begin
          if (txd_ready_next) begin
            r_state <= r_has ? S_POS_HI : S_IDLE;
          end
        end
        S_POS_HI: if (txd_ready_next) r_state <= S_POS_LO;
        S_POS_LO: if (txd_ready_next) r_state <= S_CHR;
        S_CHR:    if (txd_ready_next) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || proc_start) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef MATCH_QUEUE_DROP_COUNT_EN
  logic [7:0] r_drop_count;

  always_ff @(posedge clk) begin
    if (reset || proc_start) begin
      r_drop_count <= 8'd0;
    end else if (w_drop && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 8'd0;
`endif

endmodule

`default_nettype wire
